fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the control unit. Owns the PC, issues
//  word reads to instruction memory, delivers instr + instr_pc to decode with a
//  valid/stall handshake, and redirects on a taken branch (PCsrc) to instr_pc + ImmOp.
// PARAMETERS
//  DATA_WIDTH  32            instruction / immediate width
//  ADDR_WIDTH  32            PC and imem address width
//  RESET_PC    32'h0000_0000 first fetch address after reset
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous, active-high reset
//  PCsrc        in   1           branch taken; sampled only when instr_valid && !stall
//  ImmOp        in   DATA_WIDTH  sign-extended branch offset for the instr at output
//  stall        in   1           decode cannot accept this cycle
//  imem_req     out  1           read request, one cycle per request
//  imem_addr    out  ADDR_WIDTH  read address (= PC)
//  imem_rvalid  in   1           read data valid, >=1 cycle after imem_req
//  imem_rdata   in   DATA_WIDTH  read data
//  instr        out  DATA_WIDTH  instruction to decode
//  instr_pc     out  ADDR_WIDTH  address of instr
//  instr_valid  out  1           instr/instr_pc valid
//  fetch_fault  out  1           misaligned redirect trapped (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: PC=RESET_PC, state=IDLE, instr=NOP (32'h0000_0013), instr_pc=0,
//    instr_valid=0, imem_req=0, skid empty, kill=0, fetch_fault=0.
//  - FSM IDLE -> REQ (1 cycle, rvalid ignored). REQ: imem_req=1 iff skid empty; on
//    issue req_pc<=PC, PC<=PC+4, -> WAIT. WAIT: on imem_rvalid -> REQ.
//    Max one outstanding read. 1-cycle memory: first instr_valid 3 cycles after reset
//    release; steady throughput 1 instr / 2 cycles.
//  - Consume = instr_valid && !stall. Response capture: output reg if empty or consumed
//    this cycle, else skid buffer; instr_pc <= req_pc. Skid moves to output on consume.
//    Holding: instr/instr_pc stable while instr_valid && stall.
//  - Redirect = consume && PCsrc: target = instr_pc + ImmOp (wraps mod 2^ADDR_WIDTH).
//    Same cycle: PC<=target, output and skid invalidated, state -> REQ. If in WAIT with
//    no rvalid this cycle, set kill; next rvalid is dropped and clears kill. An rvalid
//    in the redirect cycle itself is dropped. Redirect in REQ suppresses that issue.
//  - PC increment wraps at 2^ADDR_WIDTH without flag.
//  - Async rst mid-transfer: all state to reset values immediately; late rvalid is
//    discarded (IDLE).
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: target[1:0]!=0 on redirect -> state FAULT,
//    fetch_fault=1 (sticky), imem_req=0, instr_valid=0 until rst.
//  Not defined: target[1:0] forced to 2'b00, no FAULT state, fetch_fault tied 0.
// STRUCTURE
//  cpu_pkg: fetch_state_t {IDLE,REQ,WAIT,FAULT}, INSTR_BYTES=4, NOP_INSTR=32'h0000_0013.
//  Sub-module fetch_skid_buf: one-entry {instr,pc} buffer, push/pop/flush/full.
// TESTING
//  1. rst 1->0, 1-cycle mem returning 32'h0050_0093 -> imem_addr 0 cycle1, instr_valid
//     cycle3, instr=32'h0050_0093, instr_pc=0; next imem_addr=4.
//  2. Straight line, 4 instrs, stall=0 -> instr_pc 0,4,8,C in order, none lost/duplicated.
//  3. stall=1 for 5 cycles -> instr at 0 held stable, skid holds pc 4, imem_req=0 while
//     skid full; release -> pcs 0,4,8 delivered in order.
//  4. instr_pc=8, PCsrc=1, ImmOp=-8, read to 0xC outstanding -> that response dropped,
//     next imem_addr=0, next instr_pc=0.
//  5. ImmOp=6 from instr_pc=0: with FETCH_MISALIGN_TRAP_EN fetch_fault=1, no further
//     imem_req; without, next imem_addr=4.
//  6. rst asserted during WAIT, rvalid arrives next cycle -> outputs at reset values,
//     first post-reset instr_pc=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   fetch_state_t : fetch sequencer states
//   INSTR_BYTES   : PC increment per sequential fetch
//   NOP_INSTR     : instruction presented to decode while nothing valid is held
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer used when a fetch response arrives while
// decode is still stalled on the previous instruction.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   i_push             : load i_instr/i_pc, entry becomes full
//   i_pop              : entry consumed, becomes empty
//   i_flush            : drop entry (redirect); highest priority
//   i_instr, i_pc      : entry to store
//   o_instr, o_pc      : stored entry
//   o_full             : entry valid
module fetch_skid_buf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_full
);

  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_push) begin
      r_full  <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_full  = r_full;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-word reads to instruction
// memory (at most one outstanding), hands instr/instr_pc to decode with a
// valid/stall handshake, and redirects to instr_pc + ImmOp on a taken branch.
// Build option: FETCH_MISALIGN_TRAP_EN -- when defined, a redirect to a target
// with nonzero low bits enters a sticky FAULT state; otherwise the target is
// word-aligned by clearing its low two bits and fetch_fault stays 0.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   PCsrc, ImmOp             : branch taken / offset for the instr at the output
//   stall                    : decode cannot accept this cycle
//   imem_req, imem_addr      : read request and address (= PC)
//   imem_rvalid, imem_rdata  : read response
//   instr, instr_pc          : instruction and its address to decode
//   instr_valid              : instr/instr_pc valid
//   fetch_fault              : misaligned redirect trapped (sticky)
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic                  fetch_fault
);

  fetch_state_t          r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, r_req_pc, r_instr_pc;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_valid, r_kill;

  logic                  w_consume, w_redirect, w_issue, w_rsp, w_trap;
  logic                  w_skid_push, w_skid_pop, w_skid_full;
  logic [DATA_WIDTH-1:0] w_skid_instr;
  logic [ADDR_WIDTH-1:0] w_skid_pc, w_imm, w_target_raw, w_target;

  assign w_consume    = r_valid && !stall;
  assign w_redirect   = w_consume && PCsrc;
  assign w_imm        = ADDR_WIDTH'($signed(ImmOp));
  assign w_target_raw = r_instr_pc + w_imm;
  assign w_target     = w_target_raw & ~ADDR_WIDTH'(3);

  // Issue is also held off while a killed read is still in flight so that only
  // one read is ever outstanding and responses stay unambiguous.
  assign w_issue = (r_state == REQ) && !w_skid_full && !r_kill && !w_redirect;
  assign w_rsp   = imem_rvalid && (r_state == WAIT) && !r_kill && !w_redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_fault;

  assign w_trap = w_redirect && (w_target_raw[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_fault <= 1'b0;
    else if (w_trap) r_fault <= 1'b1;
  end

  assign fetch_fault = r_fault;
`else
  assign w_trap      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    w_state_nxt = REQ;
      REQ:     if (w_issue) w_state_nxt = WAIT;
      WAIT:    if (imem_rvalid) w_state_nxt = REQ;
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = IDLE;
    endcase
    if (w_redirect) w_state_nxt = w_trap ? FAULT : REQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (w_issue) begin
      r_req_pc <= r_pc;
      r_pc     <= r_pc + ADDR_WIDTH'(INSTR_BYTES);
    end
  end

  // A redirect while a read is still in flight marks that read's response for discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_kill <= 1'b0;
    else if (w_redirect)  r_kill <= (r_state == WAIT) && !imem_rvalid;
    else if (imem_rvalid) r_kill <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr    <= DATA_WIDTH'(NOP_INSTR);
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else if (w_redirect) begin
      r_valid <= 1'b0;
    end else if (w_rsp && (!r_valid || w_consume)) begin
      r_instr    <= imem_rdata;
      r_instr_pc <= r_req_pc;
      r_valid    <= 1'b1;
    end else if (w_consume) begin
      r_valid <= w_skid_full;
      if (w_skid_full) begin
        r_instr    <= w_skid_instr;
        r_instr_pc <= w_skid_pc;
      end
    end
  end

  assign w_skid_push = w_rsp && r_valid && !w_consume;
  assign w_skid_pop  = w_consume && w_skid_full && !w_redirect;

  fetch_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_skid_push),
    .i_pop   (w_skid_pop),
    .i_flush (w_redirect),
    .i_instr (imem_rdata),
    .i_pc    (r_req_pc),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc),
    .o_full  (w_skid_full)
  );

  assign imem_req    = w_issue;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model with configurable or random latency, and a
// program-order model (expected next instruction address, advanced on every
// accepted instruction by +4 or by the branch target) checked every cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCsrc = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] ImmOp = '0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, instr_valid, fetch_fault;
  logic [31:0] imem_addr, instr, instr_pc;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .PCsrc       (PCsrc),
    .ImmOp       (ImmOp),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;

  // memory model state
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int unsigned pend_cnt = 0;
  int unsigned lat_cfg = 1;
  bit          lat_rand = 1'b0;

  // program-order model state
  logic [31:0] exp_pc = '0;
  bit          exp_fault = 1'b0;
  int unsigned idle_run = 0;
  logic [31:0] consumed[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t: bound expired", nm, $time);
  endtask

  // Start of a cycle: present this cycle's memory response.
  task automatic begin_cycle();
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memfn(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  // Mid-cycle: check outputs against the model, accept requests, advance the model.
  task automatic end_cycle();
    logic [31:0] tgt;
    @(negedge clk);
    if (rst) begin
      exp_pc    = 32'h0;
      exp_fault = 1'b0;
      idle_run  = 0;
      return;
    end
    chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, exp_fault});
    if (exp_fault) begin
      chk("fault_no_req", {31'b0, imem_req}, 32'h0);
      chk("fault_no_valid", {31'b0, instr_valid}, 32'h0);
    end
    if (imem_req) begin
      chk("one_outstanding", {31'b0, pend}, 32'h0);
      chk("req_align", {30'b0, imem_addr[1:0]}, 32'h0);
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = lat_rand ? $urandom_range(1, 3) : lat_cfg;
    end
    if (instr_valid) begin
      idle_run = 0;
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, memfn(exp_pc));
      if (!stall) begin
        consumed.push_back(instr_pc);
        if (PCsrc) begin
          tgt = exp_pc + ImmOp;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (tgt[1:0] != 2'b00) exp_fault = 1'b1;
          else exp_pc = tgt;
`else
          exp_pc = {tgt[31:2], 2'b00};
`endif
        end else begin
          exp_pc = exp_pc + 32'd4;
        end
      end
    end else if (!exp_fault) begin
      idle_run++;
      if (idle_run == 12) fail_now("liveness");
    end
  endtask

  // Reset for four cycles; returns at the end of the first cycle with rst low.
  task automatic do_reset(input int unsigned lat, input bit lrand);
    begin_cycle();
    rst = 1'b1; stall = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    lat_cfg = lat; lat_rand = lrand;
    end_cycle();
    repeat (3) begin begin_cycle(); end_cycle(); end
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    begin_cycle();
    rst = 1'b0;
    consumed.delete();
    end_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int off;

    // 1-cycle memory, first fetch timing and straight-line order
    do_reset(1, 1'b0);
    chk("c0_req", {31'b0, imem_req}, 32'h0);
    begin_cycle(); end_cycle();
    chk("c1_req", {31'b0, imem_req}, 32'h1);
    chk("c1_addr", imem_addr, 32'h0);
    begin_cycle(); end_cycle();
    begin_cycle(); end_cycle();
    chk("c3_valid", {31'b0, instr_valid}, 32'h1);
    chk("c3_instr", instr, 32'h0050_0093);
    chk("c3_pc", instr_pc, 32'h0);
    chk("c3_req", {31'b0, imem_req}, 32'h1);
    chk("c3_addr", imem_addr, 32'h4);
    for (int i = 0; i < 40 && consumed.size() < 4; i++) begin begin_cycle(); end_cycle(); end
    if (consumed.size() < 4) fail_now("straight_line");
    else for (int i = 0; i < 4; i++) chk("straight_pc", consumed[i], 32'(4 * i));

    // stall holds the output, skid takes pc 4, fetch pauses while skid is full
    do_reset(1, 1'b0);
    repeat (2) begin begin_cycle(); end_cycle(); end
    for (int c = 3; c <= 7; c++) begin
      begin_cycle(); stall = 1'b1; end_cycle();
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("stall_hold_pc", instr_pc, 32'h0);
      if (c >= 5) chk("stall_no_req", {31'b0, imem_req}, 32'h0);
    end
    begin_cycle(); stall = 1'b0; end_cycle();
    for (int i = 0; i < 40 && consumed.size() < 3; i++) begin begin_cycle(); end_cycle(); end
    if (consumed.size() < 3) fail_now("stall_release");
    else for (int i = 0; i < 3; i++) chk("stall_order_pc", consumed[i], 32'(4 * i));

    // redirect from pc 8 by -8 with the read of 0xC outstanding
    do_reset(3, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      begin_cycle();
      if (instr_valid && instr_pc == 32'h8) begin stall = 1'b1; found = 1'b1; end
      end_cycle();
    end
    if (!found) fail_now("reach_pc8");
    chk("pending_c", {31'b0, pend}, 32'h1);
    chk("pending_c_addr", pend_addr, 32'hC);
    begin_cycle(); stall = 1'b0; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8; end_cycle();
    begin_cycle(); PCsrc = 1'b0; ImmOp = '0; end_cycle();
    found = imem_req;
    for (int i = 0; i < 12 && !found; i++) begin begin_cycle(); end_cycle(); found = imem_req; end
    if (!found) fail_now("redir_req");
    else chk("redir_addr", imem_addr, 32'h0);
    found = instr_valid;
    for (int i = 0; i < 12 && !found; i++) begin begin_cycle(); end_cycle(); found = instr_valid; end
    if (!found) fail_now("redir_valid");
    else chk("redir_instr_pc", instr_pc, 32'h0);

    // misaligned target (0 + 6)
    do_reset(1, 1'b0);
    repeat (2) begin begin_cycle(); end_cycle(); end
    begin_cycle(); PCsrc = 1'b1; ImmOp = 32'd6; end_cycle();
    chk("mis_src_pc", instr_pc, 32'h0);
    begin_cycle(); PCsrc = 1'b0; ImmOp = '0; end_cycle();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault", {31'b0, fetch_fault}, 32'h1);
    repeat (5) begin
      begin_cycle(); end_cycle();
      chk("mis_no_req", {31'b0, imem_req}, 32'h0);
    end
`else
    chk("mis_req", {31'b0, imem_req}, 32'h1);
    chk("mis_addr", imem_addr, 32'h4);
    repeat (6) begin begin_cycle(); end_cycle(); end
`endif

    // asynchronous reset while waiting, response arrives the next cycle
    do_reset(2, 1'b0);
    begin_cycle(); end_cycle();
    chk("w_req", {31'b0, imem_req}, 32'h1);
    begin_cycle();
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, instr_valid}, 32'h0);
    chk("arst_instr", instr, 32'h0000_0013);
    chk("arst_instr_pc", instr_pc, 32'h0);
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    end_cycle();
    begin_cycle();
    chk("late_rvalid", {31'b0, imem_rvalid}, 32'h1);
    rst = 1'b0;
    consumed.delete();
    end_cycle();
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin begin_cycle(); end_cycle(); found = instr_valid; end
    if (!found) fail_now("post_rst_valid");
    else chk("post_rst_pc", instr_pc, 32'h0);

    // randomized traffic: random latency, stalls, branches
    do_reset(1, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      begin_cycle();
      stall = ($urandom_range(0, 9) < 3);
      PCsrc = ($urandom_range(0, 9) < 2);
      off   = int'($urandom_range(0, 32)) - 16;
      if ($urandom_range(0, 15) == 0) ImmOp = $urandom() & 32'hFFFF_FFFC;
      else ImmOp = 32'(off * 4);
`ifndef FETCH_MISALIGN_TRAP_EN
      if ($urandom_range(0, 9) == 0) ImmOp = ImmOp + 32'($urandom_range(1, 3));
`endif
      end_cycle();
    end
    if (consumed.size() < 300) fail_now("random_throughput");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
